// File: rtl/clk_edge_strobe_pkg.sv
// ---------------------------------------------------------------------------
// clk_edge_strobe_pkg
// Shared types and default parameter values for clk_edge_strobe and its
// input synchroniser.
//   state_t          : lock FSM state (IDLE / ARMED / LOCKED), 2-bit encoding
//   EDGE_CNT_W       : width of the rising-edge counter output
//   *_DEF            : default values for the top-level parameters
// ---------------------------------------------------------------------------
package clk_edge_strobe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int          EDGE_CNT_W      = 8;
  localparam int          CNT_W_DEF       = 16;
  localparam int unsigned TIMEOUT_DEF     = 32'h0000_FFFF;
  localparam int          SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_edge_strobe_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Single-bit synchroniser: STAGES flops in series on clk, async reset to 0.
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  asynchronous active-high reset
//   d    in  1  asynchronous input
//   q    out 1  synchronised output (last flop of the chain)
// ---------------------------------------------------------------------------
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_edge_strobe.sv
// ---------------------------------------------------------------------------
// clk_edge_strobe
// Brings the programmable divider's toggling output into the clk domain:
// synchronises it, emits one-cycle rise/fall enable strobes, measures the
// rise-to-rise period in clk cycles and reports lock.
// Optional stall detection is built when STROBE_STALL_DET_EN is defined.
// Ports:
//   clk           in   1           system clock
//   rst           in   1           asynchronous active-high reset
//   in_sig        in   1           divider output, asynchronous to clk
//   rise_stb      out  1           one-cycle pulse per synchronised rise
//   fall_stb      out  1           one-cycle pulse per synchronised fall
//   period        out  CNT_W       clk cycles between last two rises (sat.)
//   period_valid  out  1           period holds a complete measurement
//   edge_cnt      out  EDGE_CNT_W  rising edges since reset, wrapping
//   stalled       out  1           no rise for TIMEOUT cycles (macro only)
// ---------------------------------------------------------------------------
module clk_edge_strobe
  import clk_edge_strobe_pkg::*;
#(
  parameter int          SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_sig,
  output logic                  rise_stb,
  output logic                  fall_stb,
  output logic [CNT_W-1:0]      period,
  output logic                  period_valid,
  output logic [EDGE_CNT_W-1:0] edge_cnt,
  output logic                  stalled
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("clk_edge_strobe: SYNC_STAGES must be at least 2");
  end
  if ((TIMEOUT == 0) || (64'(TIMEOUT) >= (64'd1 << CNT_W))) begin : g_bad_timeout
    $error("clk_edge_strobe: TIMEOUT must lie in 1..2^CNT_W-1");
  end

  logic             s;
  logic             prev;
  logic             rise_det;
  logic             fall_det;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  state_t           state_nxt;
  logic             timeout_hit;
  logic             period_load;
  logic             valid_set;

  // Synchroniser: in_sig -> s
  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_sig),
    .q   (s)
  );

  // Edge detect on the synchronised level
  assign rise_det = s & ~prev;
  assign fall_det = ~s & prev;

  // Strobes, edge counter and free-running period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      edge_cnt <= '0;
      cnt      <= '0;
    end else begin
      prev     <= s;
      rise_stb <= rise_det;
      fall_stb <= fall_det;
      if (rise_det) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
      // cnt restarts at 1 so that on the next rise it equals the interval
      if (rise_det) begin
        cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef STROBE_STALL_DET_EN
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  // A rise in the same cycle as the timeout wins
  assign timeout_hit = (state != IDLE) && !rise_det && (cnt == TIMEOUT_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stalled <= 1'b0;
    end else if (rise_det) begin
      stalled <= 1'b0;
    end else if (timeout_hit) begin
      stalled <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign stalled     = 1'b0;
`endif

  // Lock FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Lock FSM: next state (fall detects never matter here)
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise_det) state_nxt = ARMED;
      ARMED:   if (rise_det) state_nxt = LOCKED;
               else if (timeout_hit) state_nxt = IDLE;
      LOCKED:  if (timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lock FSM: output decode; the first rise only arms, later rises measure
  always_comb begin
    period_load = 1'b0;
    valid_set   = 1'b0;
    unique case (state)
      ARMED, LOCKED: begin
        period_load = rise_det;
        valid_set   = rise_det;
      end
      default: begin
        period_load = 1'b0;
        valid_set   = 1'b0;
      end
    endcase
  end

  // Period / valid registers, held between rise events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      if (period_load) begin
        period <= cnt;
      end
      if (timeout_hit) begin
        period_valid <= 1'b0;
      end else if (valid_set) begin
        period_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_edge_strobe.sv
// ---------------------------------------------------------------------------
// tb_clk_edge_strobe
// Drives in_sig on the falling edge of clk and checks every output shortly
// after each rising edge against a reference built from the edge history:
// the block sees in_sig delayed by SYNC_STAGES+1 edges, measures rise-to-rise
// distance, and locks after two rises. Define STROBE_STALL_DET_EN to
// exercise the stall detector.
// ---------------------------------------------------------------------------
module tb_clk_edge_strobe;

  localparam int SS = 2;
  localparam int CW = 16;
`ifdef STROBE_STALL_DET_EN
  localparam int TO       = 50;
  localparam bit STALL_EN = 1'b1;
`else
  localparam int TO       = 16'hFFFF;
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_sig = 1'b0;
  logic          rise_stb, fall_stb, period_valid, stalled;
  logic [CW-1:0] period;
  logic [7:0]    edge_cnt;
  logic          rise4, fall4, valid4, stalled4;
  logic [3:0]    period4;
  logic [7:0]    edge_cnt4;

  clk_edge_strobe #(.SYNC_STAGES(SS), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_sig(in_sig), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .period(period), .period_valid(period_valid), .edge_cnt(edge_cnt), .stalled(stalled)
  );

  clk_edge_strobe #(.SYNC_STAGES(SS), .CNT_W(4), .TIMEOUT(15)) dut4 (
    .clk(clk), .rst(rst), .in_sig(in_sig), .rise_stb(rise4), .fall_stb(fall4),
    .period(period4), .period_valid(valid4), .edge_cnt(edge_cnt4), .stalled(stalled4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic hist[$];
  int   n, nrise, tot_rise, last_rise;
  logic exp_rise, exp_fall, exp_valid, exp_stall;
  int   exp_p16, exp_p4, exp_edge;

  // Stimulus generator state
  logic gen_v = 1'b0;
  int   gen_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic smp(input int k);
    if (k >= 1 && k <= hist.size()) return hist[k-1];
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    n = 0; nrise = 0; tot_rise = 0; last_rise = 0;
    exp_rise = 0; exp_fall = 0; exp_valid = 0; exp_stall = 0;
    exp_p16 = 0; exp_p4 = 0; exp_edge = 0;
  endtask

  task automatic model_edge();
    logic cur, old;
    int   d;
    n++;
    hist.push_back(in_sig);
    cur = smp(n - SS);
    old = smp(n - SS - 1);
    exp_rise = cur & ~old;
    exp_fall = ~cur & old;
    if (exp_rise) begin
      if (nrise >= 1) begin
        d = n - last_rise;
        exp_p16 = (d > 65535) ? 65535 : d;
        exp_p4  = (d > 15) ? 15 : d;
        exp_valid = 1'b1;
      end
      nrise++; tot_rise++;
      last_rise = n;
      exp_edge = (exp_edge + 1) % 256;
      exp_stall = 1'b0;
    end else if (STALL_EN && nrise >= 1 && (n - last_rise) == TO) begin
      exp_stall = 1'b1;
      exp_valid = 1'b0;
      nrise = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rise"}, 32'(rise_stb), 0);
    chk({tag, "_fall"}, 32'(fall_stb), 0);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_valid"}, 32'(period_valid), 0);
    chk({tag, "_edge_cnt"}, 32'(edge_cnt), 0);
    chk({tag, "_stalled"}, 32'(stalled), 0);
    chk({tag, "_period4"}, 32'(period4), 0);
  endtask

  // One clk cycle: drive at negedge, check all outputs 1 time unit after posedge
  task automatic cycle(input logic v);
    @(negedge clk);
    in_sig = v;
    @(posedge clk);
    #1;
    model_edge();
    chk("rise_stb", 32'(rise_stb), 32'(exp_rise));
    chk("fall_stb", 32'(fall_stb), 32'(exp_fall));
    chk("period", 32'(period), 32'(exp_p16));
    chk("period_valid", 32'(period_valid), 32'(exp_valid));
    chk("edge_cnt", 32'(edge_cnt), 32'(exp_edge));
    chk("stalled", 32'(stalled), 32'(exp_stall));
`ifndef STROBE_STALL_DET_EN
    chk("period_w4", 32'(period4), 32'(exp_p4));
    chk("valid_w4", 32'(valid4), 32'(exp_valid));
`endif
  endtask

  // hi/lo = phase lengths in cycles; 0 selects a random length 1..12
  task automatic run(input int hi, input int lo, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (gen_left <= 0) begin
        gen_v = ~gen_v;
        gen_left = gen_v ? hi : lo;
        if (gen_left == 0) gen_left = $urandom_range(1, 12);
      end
      cycle(gen_v);
      gen_left--;
    end
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int mark;
    model_reset();

    // Reset asserted: every output 0
    #1 rst = 1'b1;
    #1 chk_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_held");
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();

    // Constant low input: no strobes, no lock
    for (int i = 0; i < 100; i++) cycle(1'b0);
    chk("idle_edge_cnt", 32'(edge_cnt), 0);
    chk("idle_valid", 32'(period_valid), 0);

    // Period 8: rise_stb after the 3rd sampling edge
    run(4, 4, 2);
    chk("lat_early", 32'(rise_stb), 0);
    run(4, 4, 1);
    chk("lat_first_rise", 32'(rise_stb), 1);
    chk("first_rise_unlocked", 32'(period_valid), 0);
    run(4, 4, 8);
    chk("second_rise", 32'(rise_stb), 1);
    chk("period8", 32'(period), 8);
    chk("period8_valid", 32'(period_valid), 1);
    run(4, 4, 4);
    chk("fall_4_after", 32'(fall_stb), 1);
    run(4, 4, 4);
    chk("rise_4_after", 32'(rise_stb), 1);

    // Switch to half period 10 while locked: mixed interval, then 20
    run(10, 10, 14);
    chk("mixed_rise", 32'(rise_stb), 1);
    chk("mixed_period", 32'(period), 14);
    run(10, 10, 20);
    chk("period20", 32'(period), 20);
`ifndef STROBE_STALL_DET_EN
    chk("period20_w4_sat", 32'(period4), 32'hF);
    chk("period20_w4_valid", 32'(valid4), 1);
`endif

    // Random phase lengths until 300 rising edges: edge_cnt wraps to 44
    g = 0;
    while (tot_rise < 300 && g < 20000) begin
      run(0, 0, 1);
      g++;
    end
    chk("edge_wrap", 32'(edge_cnt), 44);

    // Relock on period 8, then reset mid-period
    run(4, 4, 40);
    chk("relock_period", 32'(period), 8);
    chk("relock_valid", 32'(period_valid), 1);
    #2 rst = 1'b1;
    #1 chk_zero("reset_mid");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();

    g = 0;
    do begin run(4, 4, 1); g++; end while (!rise_stb && g < 100);
    chk("post_rst_rise1", 32'(rise_stb), 1);
    chk("post_rst_rise1_valid", 32'(period_valid), 0);
    g = 0;
    do begin run(4, 4, 1); g++; end while (!rise_stb && g < 100);
    chk("post_rst_rise2_valid", 32'(period_valid), 1);

    // Freeze in_sig right after a rise
    g = 0;
    do begin run(4, 4, 1); g++; end while (!rise_stb && g < 100);
    mark = n;
    g = 0;
    while (!stalled && g < 200) begin cycle(gen_v); g++; end
`ifdef STROBE_STALL_DET_EN
    chk("stall_set", 32'(stalled), 1);
    chk("stall_delay", 32'(n - mark), 32'(TO));
    chk("stall_valid", 32'(period_valid), 0);
    g = 0;
    do begin run(4, 4, 1); g++; end while (!rise_stb && g < 100);
    chk("stall_clear", 32'(stalled), 0);
`else
    chk("no_stall", 32'(stalled), 0);
    chk("no_stall_elapsed", 32'(n - mark), 200);
    chk("no_stall_valid", 32'(period_valid), 1);
`endif
    run(4, 4, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
